// File: rtl/i2c_slave_target.sv
// I2C target with a byte-addressed register file and auto-incrementing pointer.
// Oversamples SCL/SDA on PCLK; the first byte of a write sets the pointer,
// later bytes are stored; reads stream from the pointer onward.
module i2c_slave_target #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned MEM_DEPTH  = 16,
  localparam int unsigned PW        = $clog2(MEM_DEPTH)
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_o,
  output logic          busy,
  output logic          wr_valid,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    scl_sync_q, scl_sync_d;
  logic [2:0]    sda_sync_q, sda_sync_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    rd_sh_q, rd_sh_d;
  logic          rw_q, rw_d;
  logic          got_ptr_q, got_ptr_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          sda_o_q, sda_o_d;
  logic          busy_q, busy_d;
  logic          wr_valid_q, wr_valid_d;
  logic [PW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    mem_q [MEM_DEPTH];
  logic [7:0]    mem_d [MEM_DEPTH];

  logic scl_s, sda_s, scl_rise, scl_fall, sda_rise, sda_fall, start_ev, stop_ev;
  logic [7:0] rd_byte;

  // Synchroniser chains and bus event decode (bit 1 = synced, bit 2 = previous)
  always_comb begin
    scl_sync_d = {scl_sync_q[1:0], scl_i};
    sda_sync_d = {sda_sync_q[1:0], sda_i};
    scl_s      = scl_sync_q[1];
    sda_s      = sda_sync_q[1];
    scl_rise   = scl_sync_q[1] & ~scl_sync_q[2];
    scl_fall   = ~scl_sync_q[1] & scl_sync_q[2];
    sda_rise   = sda_sync_q[1] & ~sda_sync_q[2];
    sda_fall   = ~sda_sync_q[1] & sda_sync_q[2];
    start_ev   = sda_fall & scl_s;
    stop_ev    = sda_rise & scl_s;
    rd_byte    = mem_q[ptr_q];
  end

  // Protocol FSM: next state, shift registers, pointer, register-file write
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    rd_sh_d    = rd_sh_q;
    rw_d       = rw_q;
    got_ptr_d  = got_ptr_q;
    ptr_d      = ptr_q;
    sda_o_d    = sda_o_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_d      = mem_q;
    if (stop_ev) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      sda_o_d = 1'b1;
    end else if (start_ev) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      busy_d    = 1'b1;
      sda_o_d   = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: sda_o_d = 1'b1;
        S_ADDR: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shreg_d   = {shreg_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (shreg_q[7:1] == SLAVE_ADDR) begin
              rw_d    = shreg_q[0];
              sda_o_d = 1'b0;
              state_d = S_ACK_A;
            end else begin
              sda_o_d = 1'b1;
              state_d = S_IGNORE;
            end
          end
        end
        S_ACK_A: begin
          if (scl_fall) begin
            if (!rw_q) begin
              sda_o_d   = 1'b1;
              got_ptr_d = 1'b0;
              bit_cnt_d = '0;
              state_d   = S_WR_BYTE;
            end else begin
              sda_o_d   = rd_byte[7];
              rd_sh_d   = {rd_byte[6:0], 1'b0};
              bit_cnt_d = 4'd1;
              ptr_d     = ptr_q + PW'(1);
              state_d   = S_RD_BYTE;
            end
          end
        end
        S_WR_BYTE: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shreg_d   = {shreg_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_o_d = 1'b0;
            state_d = S_WR_ACK;
            if (!got_ptr_q) begin
              ptr_d     = shreg_q[PW-1:0];
              got_ptr_d = 1'b1;
            end else begin
              mem_d[ptr_q] = shreg_q;
              wr_valid_d   = 1'b1;
              wr_addr_d    = ptr_q;
              wr_data_d    = shreg_q;
              ptr_d        = ptr_q + PW'(1);
            end
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            sda_o_d   = 1'b1;
            bit_cnt_d = '0;
            state_d   = S_WR_BYTE;
          end
        end
        S_RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_o_d = 1'b1;
              state_d = S_RD_ACK;
            end else begin
              sda_o_d   = rd_sh_q[7];
              rd_sh_d   = {rd_sh_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        S_RD_ACK: begin
          // Master NACK ends the read at the rising edge; ACK reloads on the next fall
          if (scl_rise && sda_s) begin
            sda_o_d = 1'b1;
            state_d = S_IGNORE;
          end else if (scl_fall) begin
            sda_o_d   = rd_byte[7];
            rd_sh_d   = {rd_byte[6:0], 1'b0};
            bit_cnt_d = 4'd1;
            ptr_d     = ptr_q + PW'(1);
            state_d   = S_RD_BYTE;
          end
        end
        S_IGNORE: sda_o_d = 1'b1;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // State and register file, asynchronous active-low reset
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= S_IDLE;
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      rd_sh_q    <= '0;
      rw_q       <= 1'b0;
      got_ptr_q  <= 1'b0;
      ptr_q      <= '0;
      sda_o_q    <= 1'b1;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      rd_sh_q    <= rd_sh_d;
      rw_q       <= rw_d;
      got_ptr_q  <= got_ptr_d;
      ptr_q      <= ptr_d;
      sda_o_q    <= sda_o_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      mem_q      <= mem_d;
    end
  end

  assign sda_o    = sda_o_q;
  assign busy     = busy_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_i2c_slave_target.sv
// Directed bench for i2c_slave_target: bit-banged master, logged write strobes.
module tb_i2c_slave_target;

  localparam int T = 8;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       scl = 1'b1;
  logic       sda = 1'b1;
  logic       sda_o, busy, wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  int checks = 0;
  int failures = 0;

  logic [7:0] log_a [$];
  logic [7:0] log_d [$];

  i2c_slave_target #(.SLAVE_ADDR(7'h50), .MEM_DEPTH(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .scl_i(scl), .sda_i(sda), .sda_o(sda_o),
    .busy(busy), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 PCLK = ~PCLK;

  // Record every cycle wr_valid is high
  always @(negedge PCLK) begin
    if (wr_valid) begin
      log_a.push_back({4'h0, wr_addr});
      log_d.push_back(wr_data);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] log_at(input int i);
    if (i < log_a.size()) return {log_a[i], log_d[i]};
    return 16'hxxxx;
  endfunction

  task automatic i2c_start();
    sda = 1'b1; tick(T);
    scl = 1'b1; tick(T);
    sda = 1'b0; tick(T);
    scl = 1'b0; tick(2);
  endtask

  task automatic i2c_stop();
    sda = 1'b0; tick(T);
    scl = 1'b1; tick(T);
    sda = 1'b1; tick(T);
  endtask

  task automatic send_bit(input logic b);
    sda = b;    tick(T);
    scl = 1'b1; tick(T);
    scl = 1'b0; tick(2);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda = 1'b1; tick(T);
    scl = 1'b1; tick(T / 2);
    ack = sda_o; tick(T / 2);
    scl = 1'b0; tick(2);
  endtask

  task automatic recv_byte(input logic ack_bit, output logic [7:0] r);
    r = '0;
    for (int i = 0; i < 8; i++) begin
      sda = 1'b1; tick(T);
      scl = 1'b1; tick(T / 2);
      r = {r[6:0], sda_o}; tick(T / 2);
      scl = 1'b0; tick(2);
    end
    send_bit(ack_bit);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] rd;

    // Reset values
    tick(3);
    check("rst_sda_o", 32'(sda_o), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_wr_valid", 32'(wr_valid), 32'h0);
    check("rst_wr_addr", 32'(wr_addr), 32'h0);
    check("rst_wr_data", 32'(wr_data), 32'h0);
    PRESETn = 1'b1;
    tick(4);

    // Write: ptr 3, data 0x11, 0x22
    i2c_start();
    check("t1_busy_start", 32'(busy), 32'h1);
    send_byte(8'hA0, ack); check("t1_ack_addr", 32'(ack), 32'h0);
    send_byte(8'h03, ack); check("t1_ack_ptr", 32'(ack), 32'h0);
    send_byte(8'h11, ack); check("t1_ack_d0", 32'(ack), 32'h0);
    send_byte(8'h22, ack); check("t1_ack_d1", 32'(ack), 32'h0);
    i2c_stop(); tick(4);
    check("t1_busy_stop", 32'(busy), 32'h0);
    check("t1_wr_count", 32'(log_a.size()), 32'd2);
    check("t1_wr0", 32'(log_at(0)), 32'h0311);
    check("t1_wr1", 32'(log_at(1)), 32'h0422);

    // Pointer-only write, repeated START, read two bytes
    i2c_start();
    send_byte(8'hA0, ack); check("t2_ack_addr", 32'(ack), 32'h0);
    send_byte(8'h03, ack); check("t2_ack_ptr", 32'(ack), 32'h0);
    i2c_start();
    send_byte(8'hA1, ack); check("t2_ack_raddr", 32'(ack), 32'h0);
    recv_byte(1'b0, rd);   check("t2_rd0", 32'(rd), 32'h11);
    recv_byte(1'b1, rd);   check("t2_rd1", 32'(rd), 32'h22);
    tick(4);
    check("t2_sda_after_nack", 32'(sda_o), 32'h1);
    i2c_stop(); tick(4);
    check("t2_busy_stop", 32'(busy), 32'h0);
    check("t2_wr_count", 32'(log_a.size()), 32'd2);

    // Wrong address is NACKed and its data ignored; then ptr 0x0F wraps
    i2c_start();
    send_byte(8'hA2, ack); check("t3_nack_addr", 32'(ack), 32'h1);
    send_byte(8'h55, ack); check("t3_nack_data", 32'(ack), 32'h1);
    i2c_stop(); tick(4);
    check("t3_wr_count", 32'(log_a.size()), 32'd2);
    i2c_start();
    send_byte(8'hA0, ack); check("t4_ack_addr", 32'(ack), 32'h0);
    send_byte(8'h0F, ack); check("t4_ack_ptr", 32'(ack), 32'h0);
    send_byte(8'hAA, ack); check("t4_ack_d0", 32'(ack), 32'h0);
    send_byte(8'hBB, ack); check("t4_ack_d1", 32'(ack), 32'h0);
    i2c_stop(); tick(4);
    check("t4_wr_count", 32'(log_a.size()), 32'd4);
    check("t4_wr_wrap0", 32'(log_at(2)), 32'h0FAA);
    check("t4_wr_wrap1", 32'(log_at(3)), 32'h00BB);
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h0F, ack);
    i2c_start();
    send_byte(8'hA1, ack); check("t4_ack_raddr", 32'(ack), 32'h0);
    recv_byte(1'b0, rd);   check("t4_rd15", 32'(rd), 32'hAA);
    recv_byte(1'b1, rd);   check("t4_rd0", 32'(rd), 32'hBB);
    i2c_stop(); tick(4);

    // STOP after four data bits: byte discarded
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h03, ack);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_stop(); tick(4);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_sda_o", 32'(sda_o), 32'h1);
    check("t5_wr_count", 32'(log_a.size()), 32'd4);
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h03, ack);
    i2c_start();
    send_byte(8'hA1, ack);
    recv_byte(1'b1, rd);   check("t5_mem3_kept", 32'(rd), 32'h11);
    i2c_stop(); tick(4);

    // Async reset while the target drives SDA low during a read
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h04, ack);
    i2c_start();
    send_byte(8'hA1, ack); check("t6_ack_raddr", 32'(ack), 32'h0);
    tick(4);
    check("t6_sda_low_pre", 32'(sda_o), 32'h0);
    check("t6_busy_pre", 32'(busy), 32'h1);
    #2 PRESETn = 1'b0;
    #1;
    check("t6_sda_rst", 32'(sda_o), 32'h1);
    check("t6_busy_rst", 32'(busy), 32'h0);
    scl = 1'b0; tick(2);
    sda = 1'b1; tick(2);
    scl = 1'b1; tick(4);
    PRESETn = 1'b1; tick(4);
    check("t6_busy_after", 32'(busy), 32'h0);
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h00, ack);
    i2c_start();
    send_byte(8'hA1, ack);
    recv_byte(1'b1, rd);   check("t6_rd0_cleared", 32'(rd), 32'h00);
    i2c_stop(); tick(4);
    check("t6_wr_count", 32'(log_a.size()), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
